// File: rtl/unidade_mul_div_if.sv
// Request/response bundle between the execute-stage control and the
// iterative RV32M multiply/divide unit.
//   master: start, flush, funct3, op_a, op_b, rd_in -> ; <- busy, valid, result, rd_out
//   slave : the mul/div unit side of the same signals
interface unidade_mul_div_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic            flush;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      rd_in;
    logic            busy;
    logic            valid;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output start, flush, funct3, op_a, op_b, rd_in,
        input  busy, valid, result, rd_out
    );

    modport slave (
        input  start, flush, funct3, op_a, op_b, rd_in,
        output busy, valid, result, rd_out
    );
endinterface

// File: rtl/unidade_mul_div.sv
// Iterative RV32M multiply/divide unit, one result bit per clock.
// Ports:
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   bus      : slave side of unidade_mul_div_if (start/flush/funct3/op_a/op_b/rd_in in,
//              busy/valid/result/rd_out out, all outputs registered)
module unidade_mul_div #(
    parameter int unsigned XLEN = 32
) (
    input  logic              clk,
    input  logic              rst,
    unidade_mul_div_if.slave  bus
);
    localparam int unsigned    CW      = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {OCIOSO, CALC, FIM} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [2:0]      f3, f3_n;
    logic            sign_a, sign_a_n, sign_b, sign_b_n;
    logic [XLEN-1:0] mag_a, mag_a_n, mag_b, mag_b_n;
    logic [XLEN-1:0] hi, hi_n, lo, lo_n;
    logic [4:0]      rd_q, rd_q_n, rd_out, rd_out_n;
    logic [XLEN-1:0] result, result_n;
    logic            valid, valid_n, busy, busy_n;

    // Operand decode at the accepting edge
    logic            in_sa, in_sb, in_sign_a, in_sign_b;
    logic [XLEN-1:0] in_mag_a, in_mag_b, special_res;
    logic            div_zero, div_ovf;

    always_comb begin
        case (bus.funct3)
            3'b001, 3'b100, 3'b110: begin in_sa = 1'b1; in_sb = 1'b1; end
            3'b010:                 begin in_sa = 1'b1; in_sb = 1'b0; end
            default:                begin in_sa = 1'b0; in_sb = 1'b0; end
        endcase
        in_sign_a   = in_sa & bus.op_a[XLEN-1];
        in_sign_b   = in_sb & bus.op_b[XLEN-1];
        in_mag_a    = in_sign_a ? -bus.op_a : bus.op_a;
        in_mag_b    = in_sign_b ? -bus.op_b : bus.op_b;
        div_zero    = (bus.op_b == '0);
        div_ovf     = !bus.funct3[0] && (bus.op_a == MIN_NEG) && (bus.op_b == '1);
        if (bus.funct3[1]) special_res = div_zero ? bus.op_a : '0;
        else               special_res = div_zero ? '1 : MIN_NEG;
    end

    // One iteration: shift-add multiply on {hi,lo}, or restoring divide with
    // hi = partial remainder and lo = dividend shifting into quotient
    logic [XLEN:0]     sum, shifted;
    logic [XLEN-1:0]   diff, step_hi, step_lo;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, final_res;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, mag_a} : '0);
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted[XLEN-1:0] - mag_b;
        if (f3[2]) begin
            if (shifted >= {1'b0, mag_b}) begin
                step_hi = diff;
                step_lo = {lo[XLEN-2:0], 1'b1};
            end else begin
                step_hi = shifted[XLEN-1:0];
                step_lo = {lo[XLEN-2:0], 1'b0};
            end
        end else begin
            step_hi = sum[XLEN:1];
            step_lo = {sum[0], lo[XLEN-1:1]};
        end
        prod   = {step_hi, step_lo};
        prod_s = (sign_a ^ sign_b) ? -prod : prod;
        quo_s  = (sign_a ^ sign_b) ? -step_lo : step_lo;
        rem_s  = sign_a ? -step_hi : step_hi;
        if (f3[2])               final_res = f3[1] ? rem_s : quo_s;
        else if (f3[1:0] == 2'b00) final_res = prod_s[XLEN-1:0];
        else                     final_res = prod_s[2*XLEN-1:XLEN];
    end

    // Next-state and next-output logic
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        f3_n     = f3;
        sign_a_n = sign_a;
        sign_b_n = sign_b;
        mag_a_n  = mag_a;
        mag_b_n  = mag_b;
        hi_n     = hi;
        lo_n     = lo;
        rd_q_n   = rd_q;
        rd_out_n = rd_out;
        result_n = result;
        valid_n  = 1'b0;
        case (state)
            OCIOSO: begin
                if (bus.start) begin
                    f3_n     = bus.funct3;
                    rd_q_n   = bus.rd_in;
                    sign_a_n = in_sign_a;
                    sign_b_n = in_sign_b;
                    mag_a_n  = in_mag_a;
                    mag_b_n  = in_mag_b;
                    hi_n     = '0;
                    lo_n     = bus.funct3[2] ? in_mag_a : in_mag_b;
                    cnt_n    = '0;
                    if (bus.funct3[2] && (div_zero || div_ovf)) begin
                        result_n = special_res;
                        rd_out_n = bus.rd_in;
                        valid_n  = 1'b1;
                        state_n  = FIM;
                    end else begin
                        state_n  = CALC;
                    end
                end
            end
            CALC: begin
                if (bus.flush) begin
                    state_n = OCIOSO;
                end else begin
                    hi_n  = step_hi;
                    lo_n  = step_lo;
                    cnt_n = cnt + 1'b1;
                    if (cnt == '1) begin
                        result_n = final_res;
                        rd_out_n = rd_q;
                        valid_n  = 1'b1;
                        state_n  = FIM;
                    end
                end
            end
            FIM:     state_n = OCIOSO;
            default: state_n = OCIOSO;
        endcase
        busy_n = (state_n != OCIOSO);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= OCIOSO;
            cnt    <= '0;
            f3     <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            mag_a  <= '0;
            mag_b  <= '0;
            hi     <= '0;
            lo     <= '0;
            rd_q   <= '0;
            rd_out <= '0;
            result <= '0;
            valid  <= 1'b0;
            busy   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            f3     <= f3_n;
            sign_a <= sign_a_n;
            sign_b <= sign_b_n;
            mag_a  <= mag_a_n;
            mag_b  <= mag_b_n;
            hi     <= hi_n;
            lo     <= lo_n;
            rd_q   <= rd_q_n;
            rd_out <= rd_out_n;
            result <= result_n;
            valid  <= valid_n;
            busy   <= busy_n;
        end
    end

    assign bus.busy   = busy;
    assign bus.valid  = valid;
    assign bus.result = result;
    assign bus.rd_out = rd_out;
endmodule

// File: doc/unidade_mul_div.md
# unidade_mul_div

Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the 32×32 register bank. It takes both read ports (rs1/rs2 data) plus funct3 and the destination index, and computes one result bit per cycle. It returns result, rd and a one-cycle valid pulse, which drive the bank's write_data, rd and reg_write inputs.

## Interface
- XLEN, 32, operand/result width; the only supported value is 32.
- clk  in  1  rising-edge clock shared with the register bank
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; sampled only in OCIOSO
- flush  in  1  synchronous abort of the operation in flight
- funct3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- op_a  in  32  rs1 data (read_data1)
- op_b  in  32  rs2 data (read_data2)
- rd_in  in  5  destination register index
- busy  out  1  high in CALC and FIM
- valid  out  1  one-cycle pulse; drives reg_write
- result  out  32  registered result; drives write_data
- rd_out  out  5  latched rd_in; drives rd

## Operation
- States:
  - OCIOSO (reset).
  - CALC: 32 iterations; 5-bit counter 0..31.
  - FIM: valid=1 for one cycle.
- OCIOSO with start=1 at an edge:
  - Latch funct3 and rd_in.
  - Latch the magnitudes of op_a/op_b, plus the sign flags, per signedness:
    - MULH, DIV, REM: both operands signed.
    - MULHSU: op_a signed, op_b unsigned.
    - MULHU, DIVU, REMU: both unsigned.
    - MUL: signedness irrelevant (low word).
  - Clear the counter and go to CALC.
- Division special cases bypass CALC and go straight to FIM with the result loaded on the same edge:
  - Divisor 0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → op_a.
  - DIV/REM with op_a=0x80000000 and op_b=0xFFFFFFFF: DIV → 0x80000000, REM → 0.
- CALC, multiply:
  - Shift-add on magnitudes into a 64-bit accumulator, one multiplier bit per edge.
  - Final product is negated (two's complement, 64-bit) if the sign flags differ.
  - MUL takes the low 32 bits; MULH, MULHSU and MULHU take the high 32 bits.
- CALC, divide:
  - Restoring division, one quotient bit per edge; 33-bit partial remainder.
  - Quotient is negated if the sign flags differ (DIV).
  - Remainder takes the sign of op_a (REM).
- On the edge completing iteration 31:
  - Sign correction and selection are combinational.
  - result and rd_out are loaded; state → FIM.
- FIM → OCIOSO on the next edge unconditionally. start during CALC or FIM is ignored, not queued.
- flush=1 at any edge in CALC or FIM:
  - State → OCIOSO; valid stays 0; result and rd_out keep their old values.
  - flush takes priority over start and over completion.
- result and rd_out hold their value until the next completion; valid is the only qualifier.
- rd_in=0 still produces valid; the register bank discards writes to x0.

## Timing
- Reset (asynchronous, immediate): state OCIOSO, counter 0, busy 0, valid 0, result 0x00000000, rd_out 0.
- Normal op, start accepted at edge N:
  - busy high from N.
  - Iterations at edges N+1..N+32.
  - valid high between edges N+32 and N+33.
  - busy low after N+33.
  - Latency 32 cycles start→valid; next start accepted at N+34 earliest (34-cycle issue interval).
- Special-case division, start at edge N: valid and busy high between N and N+1; OCIOSO at N+1.
- Operands are sampled only at the accepting edge; op_a and op_b may change afterwards.
- rst asserted mid-CALC: all outputs go to reset values without waiting for clk; no valid is produced.
- busy is registered; start must be generated from the previous-cycle busy by the control stage.

## Test plan
- MUL 7 × 0xFFFFFFFD (-3), rd_in=5 → result 0xFFFFFFEB and rd_out 5, valid exactly 32 edges after start; busy high for 33 cycles.
- High-word multiplies:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Divides:
  - DIV 0xFFFFFFF9 (-7) / 2 → 0xFFFFFFFD.
  - REM -7 % 2 → 0xFFFFFFFF.
  - DIVU 0xFFFFFFFF / 2 → 0x7FFFFFFF.
  - REMU 100 % 7 → 2.
- Special cases (each valid one cycle after start):
  - DIV 5 / 0 → 0xFFFFFFFF.
  - REMU 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Control:
  - start pulsed at iterations 3 and 31 → ignored; the original result is unchanged.
  - flush at iteration 10 → no valid, busy 0 next cycle, result unchanged.
  - A new start on the following edge completes correctly.
- Reset: rst pulsed mid-edge at iteration 20 → busy, valid, result and rd_out go to 0 asynchronously; the unit accepts a new start after rst falls.
